// File: rtl/arith_exti_reg.sv
// Registered zero/sign extension stage with a 2-entry skid buffer.
// Both the valid/data path and the ready path are fully registered.
module arith_exti_reg #(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned OUT_WIDTH = 32,
    parameter bit          SIGNED    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [IN_WIDTH-1:0]  a_data,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [OUT_WIDTH-1:0] result_data
);

    generate
        if (IN_WIDTH < 1 || OUT_WIDTH < IN_WIDTH) begin : g_bad_width
            $error("arith_exti_reg: requires IN_WIDTH >= 1 and OUT_WIDTH >= IN_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [IN_WIDTH-1:0] main_q, main_d;
    logic [IN_WIDTH-1:0] skid_q, skid_d;
    logic                ready_q;
    logic                fire_in;
    logic                fire_out;

    assign fire_in  = a_valid && ready_q;
    assign fire_out = (state != EMPTY) && result_ready;

    always_comb begin
        state_d = state;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state)
            EMPTY: begin
                if (fire_in) begin
                    main_d  = a_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (fire_in && fire_out) begin
                    main_d = a_data;
                end else if (fire_out) begin
                    state_d = EMPTY;
                end else if (fire_in) begin
                    skid_d  = a_data;
                    state_d = TWO;
                end
            end
            TWO: begin
                // ready_q is low here, so only the drain side can move
                if (result_ready) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= (state_d != TWO);
        end
    end

    assign a_ready      = ready_q;
    assign result_valid = (state != EMPTY);

    always_comb begin
        if (SIGNED) begin
            result_data = OUT_WIDTH'($signed(main_q));
        end else begin
            result_data = OUT_WIDTH'(main_q);
        end
    end

endmodule

// File: tb/tb_arith_exti_reg.sv
// Directed + randomized bench for arith_exti_reg; four parameterisations run in lockstep
// against a queue-based reference of the buffer contents.
module tb_arith_exti_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid;
    logic [15:0] a_data;
    logic        result_ready;

    logic        ar0, ar1, ar2, ar3;
    logic        rv0, rv1, rv2, rv3;
    logic [31:0] r0, r1;
    logic [7:0]  r2;
    logic [15:0] r3;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [15:0] q[$];
    logic        exp_ready = 1'b0;

    always #5 clk = ~clk;

    arith_exti_reg #(.IN_WIDTH(16), .OUT_WIDTH(32), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .a_valid(a_valid), .a_ready(ar0), .a_data(a_data),
        .result_valid(rv0), .result_ready(result_ready), .result_data(r0));

    arith_exti_reg #(.IN_WIDTH(16), .OUT_WIDTH(32), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .a_valid(a_valid), .a_ready(ar1), .a_data(a_data),
        .result_valid(rv1), .result_ready(result_ready), .result_data(r1));

    arith_exti_reg #(.IN_WIDTH(1), .OUT_WIDTH(8), .SIGNED(1'b1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .a_valid(a_valid), .a_ready(ar2), .a_data(a_data[0:0]),
        .result_valid(rv2), .result_ready(result_ready), .result_data(r2));

    arith_exti_reg #(.IN_WIDTH(16), .OUT_WIDTH(16), .SIGNED(1'b1)) dut_eq (
        .clk(clk), .rst_n(rst_n), .a_valid(a_valid), .a_ready(ar3), .a_data(a_data),
        .result_valid(rv3), .result_ready(result_ready), .result_data(r3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock cycle: drive at negedge, check outputs, advance the reference, then step.
    task automatic cyc(input bit rn, input bit av, input logic [15:0] ad, input bit rr);
        logic [15:0] e;
        bit          fin, fout;
        rst_n        = rn;
        a_valid      = av;
        a_data       = ad;
        result_ready = rr;
        #1;
        chk("valid_u", rv0, q.size() != 0);
        chk("valid_w1", rv2, q.size() != 0);
        chk("ready_u", ar0, exp_ready);
        chk("ready_s", ar1, exp_ready);
        if (q.size() != 0) begin
            e = q[0];
            chk("data_u", r0, {16'h0000, e});
            chk("data_s", r1, {{16{e[15]}}, e});
            chk("data_w1", r2, {{7{e[0]}}, e[0]});
            chk("data_eq", r3, e);
        end
        fin  = av && exp_ready;
        fout = (q.size() != 0) && rr;
        if (!rn) begin
            q.delete();
            exp_ready = 1'b0;
        end else begin
            if (fout) void'(q.pop_front());
            if (fin) q.push_back(ad);
            exp_ready = (q.size() < 2);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; a_valid = 1'b0; a_data = '0; result_ready = 1'b0;
        @(negedge clk);

        // Reset, then release: ready rises after the first non-reset edge
        cyc(0, 0, 16'h0, 0);
        cyc(0, 1, 16'hFFFF, 1);
        chk("rst_data_u", r0, 32'h0);
        chk("rst_data_s", r1, 32'h0);
        cyc(1, 0, 16'h0, 0);
        chk("ready_after_rst", ar0, 1'b1);

        // result_ready toggling while empty
        cyc(1, 0, 16'h0, 1);
        cyc(1, 0, 16'h0, 0);
        cyc(1, 0, 16'h0, 1);

        // Single token, latency 1, valid for one cycle only
        cyc(1, 1, 16'h8001, 1);
        chk("ext_u_8001", r0, 32'h0000_8001);
        chk("ext_s_8001", r1, 32'hFFFF_8001);
        chk("ext_w1_one", r2, 8'hFF);
        chk("ext_eq_8001", r3, 16'h8001);
        cyc(1, 0, 16'h0, 1);
        chk("pulse_len", rv0, 1'b0);
        cyc(1, 1, 16'h7FFF, 1);
        chk("ext_s_7fff", r1, 32'h0000_7FFF);
        cyc(1, 1, 16'h0002, 1);
        chk("ext_w1_zero", r2, 8'h00);
        chk("ext_u_0002", r0, 32'h0000_0002);
        cyc(1, 0, 16'h0, 1);

        // Backpressure: two accepted, third held on the input
        cyc(1, 1, 16'h0001, 0);
        cyc(1, 1, 16'h0002, 0);
        chk("bp_ready_low", ar0, 1'b0);
        cyc(1, 1, 16'h0003, 0);
        cyc(1, 1, 16'h0003, 0);
        chk("bp_stall_data", r0, 32'h0000_0001);
        cyc(1, 1, 16'h0003, 1);
        chk("bp_second", r0, 32'h0000_0002);
        chk("bp_ready_back", ar0, 1'b1);
        cyc(1, 1, 16'h0003, 1);
        chk("bp_third", r0, 32'h0000_0003);
        cyc(1, 0, 16'h0, 1);
        cyc(1, 0, 16'h0, 1);

        // Streaming at full rate
        for (int i = 0; i < 100; i++) cyc(1, 1, 16'($urandom), 1);
        cyc(1, 0, 16'h0, 1);
        cyc(1, 0, 16'h0, 1);

        // Random stalls on both sides
        for (int i = 0; i < 1000; i++)
            cyc(1, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));

        // Reset while both slots are full
        for (int i = 0; i < 4; i++) cyc(1, 0, 16'h0, 1);
        cyc(1, 1, 16'hAAAA, 0);
        cyc(1, 1, 16'hBBBB, 0);
        chk("two_full_ready", ar0, 1'b0);
        cyc(0, 1, 16'hCCCC, 1);
        chk("rst2_valid", rv0, 1'b0);
        chk("rst2_ready", ar0, 1'b0);
        chk("rst2_data", r0, 32'h0);
        cyc(1, 1, 16'h1234, 1);
        cyc(1, 1, 16'h1234, 1);
        chk("post_rst_first", r0, 32'h0000_1234);
        cyc(1, 0, 16'h0, 1);
        cyc(1, 0, 16'h0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
